// File: rtl/uart_rx_if.sv
// Bundle of serial line, frame configuration and result strobes for uart_rx.
interface uart_rx_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: oversampled bits with 3-sample majority vote, optional parity,
// and one-cycle result pulses in the cycle after the stop bit ends.
module uart_rx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input logic      CLK,
    input logic      RST,
    uart_rx_if.slave bus
);
    localparam int unsigned EDGE_W = 6;
    localparam int unsigned BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_next;
    logic [EDGE_W-1:0]     edge_cnt, prescale_lat, half;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  par_en_lat, par_typ_lat, par_bad;
    logic [2:0]            samples;
    logic [DATA_WIDTH-1:0] shift_reg, p_data;
    logic                  data_valid, par_err, stp_err;
    logic                  start_c, bit_end_c, sample_c, bit_val_c;

    function automatic logic [EDGE_W-1:0] decode_prescale(input logic [5:0] raw);
        case (raw)
            6'd16:   return EDGE_W'(16);
            6'd32:   return EDGE_W'(32);
            default: return EDGE_W'(8);
        endcase
    endfunction

    assign half = prescale_lat >> 1;

    // Bit timing strobes and majority vote over the three mid-bit samples.
    always_comb begin
        start_c   = (state == IDLE) && !bus.RX_IN;
        bit_end_c = (state != IDLE) && (edge_cnt == prescale_lat - EDGE_W'(1));
        sample_c  = (state != IDLE) &&
                    ((edge_cnt == half - EDGE_W'(1)) || (edge_cnt == half) ||
                     (edge_cnt == half + EDGE_W'(1)));
        bit_val_c = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                    (samples[1] & samples[2]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_c)   state_next = START;
            START:   if (bit_end_c) state_next = bit_val_c ? IDLE : DATA;
            DATA:    if (bit_end_c && (bit_cnt == LAST_BIT))
                         state_next = par_en_lat ? PARITY : STOP;
            PARITY:  if (bit_end_c) state_next = STOP;
            STOP:    if (bit_end_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: counters, deserializer, parity tracking and result strobes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt     <= '0;
            bit_cnt      <= '0;
            prescale_lat <= EDGE_W'(8);
            par_en_lat   <= 1'b0;
            par_typ_lat  <= 1'b0;
            par_bad      <= 1'b0;
            samples      <= '0;
            shift_reg    <= '0;
            p_data       <= '0;
            data_valid   <= 1'b0;
            par_err      <= 1'b0;
            stp_err      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;

            // The detecting IDLE cycle is edge 0, so the start bit resumes at edge 1.
            if (start_c) begin
                prescale_lat <= decode_prescale(bus.PRESCALE);
                par_en_lat   <= bus.PAR_EN;
                par_typ_lat  <= bus.PAR_TYP;
                par_bad      <= 1'b0;
                edge_cnt     <= EDGE_W'(1);
            end else if ((state == IDLE) || bit_end_c) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + EDGE_W'(1);
            end

            if (sample_c) samples <= {samples[1:0], bus.RX_IN};

            if (bit_end_c) begin
                case (state)
                    DATA: begin
                        shift_reg <= DATA_WIDTH'({bit_val_c, shift_reg} >> 1);
                        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BIT_W'(1);
                    end
                    PARITY: par_bad <= bit_val_c != ((^shift_reg) ^ par_typ_lat);
                    STOP: begin
                        if (bit_val_c && !par_bad) begin
                            p_data     <= shift_reg;
                            data_valid <= 1'b1;
                        end
                        par_err <= par_bad;
                        stp_err <= !bit_val_c;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.P_DATA     = p_data;
    assign bus.DATA_VALID = data_valid;
    assign bus.PAR_ERR    = par_err;
    assign bus.STP_ERR    = stp_err;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames scored
// against a frame-level model of expected result pulses.
module tb_uart_rx;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [31:0]  cyc;
        logic         dv;
        logic         pe;
        logic         se;
        logic [W-1:0] pd;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    ev_t        events[$];
    ev_t        expq[$];
    logic [W-1:0] model_pd;

    uart_rx_if #(.DATA_WIDTH(W)) bus ();
    uart_rx #(.DATA_WIDTH(W)) dut (.CLK(clk), .RST(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every cycle showing any result pulse, away from the active edge.
    always @(negedge clk) begin
        if (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)
            events.push_back(mk_ev(cyc, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA));
    end

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation still running at cycle %0d, limit 95000", cyc);
        $fatal(1);
    end

    function automatic ev_t mk_ev(input int c, input logic dv, input logic pe,
                                  input logic se, input logic [W-1:0] pd);
        ev_t e;
        e.cyc = 32'(c); e.dv = dv; e.pe = pe; e.se = se; e.pd = pd;
        return e;
    endfunction

    function automatic string ev_str(input ev_t e);
        return $sformatf("cyc=%0d dv=%b pe=%b se=%b pd=%h", e.cyc, e.dv, e.pe, e.se, e.pd);
    endfunction

    function automatic int eff_p(input int p);
        return (p == 16 || p == 32) ? p : 8;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one frame; returns the cycle index of start edge 0.
    task automatic send_frame(input int pcfg, input bit pen, input bit ptyp,
                              input logic [W-1:0] data, input bit par_bit,
                              input bit stop_bit, input bit noise, input bit scramble,
                              output int t0);
        int p;
        int ne;
        bit bits[$];
        p = eff_p(pcfg);
        bus.PRESCALE = 6'(pcfg);
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        bits.push_back(1'b0);
        for (int i = 0; i < int'(W); i++) bits.push_back(data[i]);
        if (pen) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        t0 = cyc;
        foreach (bits[k]) begin
            ne = noise ? int'($urandom_range(p - 1, 1)) : -1;
            for (int e = 0; e < p; e++) begin
                bus.RX_IN = (e == ne) ? ~bits[k] : bits[k];
                tick(1);
            end
            if (scramble && k == 0) begin
                bus.PRESCALE = 6'($urandom);
                bus.PAR_EN   = 1'($urandom);
                bus.PAR_TYP  = 1'($urandom);
            end
        end
        bus.RX_IN = 1'b1;
    endtask

    // Frame-level model: result cycle, flags and P_DATA from the frame contents.
    task automatic expect_frame(input int pcfg, input bit pen, input bit ptyp,
                                input logic [W-1:0] data, input bit par_bit,
                                input bit stop_bit, input int t0);
        bit pe;
        bit dv;
        pe = pen && (par_bit != ((^data) ^ ptyp));
        dv = !pe && stop_bit;
        if (dv) model_pd = data;
        expq.push_back(mk_ev(t0 + eff_p(pcfg) * (int'(W) + 2 + (pen ? 1 : 0)),
                             dv, pe, !stop_bit, model_pd));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.RX_IN = 1'b1; bus.PRESCALE = 6'd8; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        tick(3);
        checks++;
        if (bus.P_DATA !== 8'h00) begin
            errors++; $display("FAIL reset_p_data: got %h want 00", bus.P_DATA);
        end
        checks++;
        if ({bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got dv/pe/se=%b%b%b want 000",
                     bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR);
        end
        rst = 1'b0;
        tick(5);
        checks++;
        if (events.size() !== 0) begin
            errors++; $display("FAIL reset_idle_quiet: got %0d pulses want 0", events.size());
        end
    endtask

    task automatic test_no_parity();
        int t0;
        ev_t e;
        events.delete();
        send_frame(8, 0, 0, 8'hA5, 0, 1, 0, 0, t0);
        tick(4);
        checks++;
        e = mk_ev(t0 + 80, 1, 0, 0, 8'hA5);
        if (events.size() !== 1 || events[0] !== e) begin
            errors++;
            $display("FAIL good_a5: got %0d events first %s want %s", events.size(),
                     events.size() > 0 ? ev_str(events[0]) : "none", ev_str(e));
        end
        events.delete();
        send_frame(8, 0, 0, 8'h77, 0, 0, 0, 0, t0);
        tick(4);
        checks++;
        e = mk_ev(t0 + 80, 0, 0, 1, 8'hA5);
        if (events.size() !== 1 || events[0] !== e) begin
            errors++;
            $display("FAIL stop_err: got %0d events first %s want %s", events.size(),
                     events.size() > 0 ? ev_str(events[0]) : "none", ev_str(e));
        end
    endtask

    task automatic test_parity();
        int t0;
        ev_t e;
        events.delete();
        send_frame(16, 1, 0, 8'h3C, 0, 1, 0, 0, t0);
        tick(4);
        checks++;
        e = mk_ev(t0 + 176, 1, 0, 0, 8'h3C);
        if (events.size() !== 1 || events[0] !== e) begin
            errors++;
            $display("FAIL parity_even_good: got %0d events first %s want %s", events.size(),
                     events.size() > 0 ? ev_str(events[0]) : "none", ev_str(e));
        end
        events.delete();
        send_frame(8, 1, 1, 8'h01, 1, 1, 0, 0, t0);
        tick(4);
        checks++;
        e = mk_ev(t0 + 88, 0, 1, 0, 8'h3C);
        if (events.size() !== 1 || events[0] !== e) begin
            errors++;
            $display("FAIL parity_odd_err: got %0d events first %s want %s", events.size(),
                     events.size() > 0 ? ev_str(events[0]) : "none", ev_str(e));
        end
        events.delete();
        send_frame(8, 1, 0, 8'h0F, 1, 0, 0, 0, t0);
        tick(4);
        checks++;
        e = mk_ev(t0 + 88, 0, 1, 1, 8'h3C);
        if (events.size() !== 1 || events[0] !== e) begin
            errors++;
            $display("FAIL both_errors: got %0d events first %s want %s", events.size(),
                     events.size() > 0 ? ev_str(events[0]) : "none", ev_str(e));
        end
    endtask

    task automatic test_glitch();
        int t0;
        int t1;
        ev_t e;
        events.delete();
        bus.PRESCALE = 6'd8; bus.PAR_EN = 1'b0;
        t0 = cyc;
        bus.RX_IN = 1'b0; tick(2);
        bus.RX_IN = 1'b1; tick(6);
        checks++;
        if (events.size() !== 0 || bus.P_DATA !== 8'h3C) begin
            errors++;
            $display("FAIL glitch_quiet: got %0d pulses p_data=%h want 0 pulses p_data=3c",
                     events.size(), bus.P_DATA);
        end
        // A frame starting exactly at clock 8 is only seen if the receiver is back in IDLE.
        send_frame(8, 0, 0, 8'hC3, 0, 1, 0, 0, t1);
        tick(4);
        checks++;
        e = mk_ev(t0 + 88, 1, 0, 0, 8'hC3);
        if (events.size() !== 1 || events[0] !== e) begin
            errors++;
            $display("FAIL glitch_then_frame: got %0d events first %s want %s", events.size(),
                     events.size() > 0 ? ev_str(events[0]) : "none", ev_str(e));
        end
    endtask

    task automatic test_config_latch();
        int t0;
        ev_t e;
        events.delete();
        send_frame(32, 1, 1, 8'h96, 1, 1, 0, 1, t0);
        tick(4);
        checks++;
        e = mk_ev(t0 + 352, 1, 0, 0, 8'h96);
        if (events.size() !== 1 || events[0] !== e) begin
            errors++;
            $display("FAIL config_latch: got %0d events first %s want %s", events.size(),
                     events.size() > 0 ? ev_str(events[0]) : "none", ev_str(e));
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        int t1;
        ev_t e;
        events.delete();
        send_frame(32, 0, 0, 8'h55, 0, 1, 0, 0, t0);
        send_frame(32, 0, 0, 8'hAA, 0, 1, 0, 0, t1);
        tick(4);
        checks++;
        if (events.size() !== 2) begin
            errors++; $display("FAIL b2b_count: got %0d pulses want 2", events.size());
        end else begin
            checks++;
            e = mk_ev(t0 + 320, 1, 0, 0, 8'h55);
            if (events[0] !== e) begin
                errors++; $display("FAIL b2b_first: got %s want %s", ev_str(events[0]), ev_str(e));
            end
            checks++;
            e = mk_ev(t0 + 640, 1, 0, 0, 8'hAA);
            if (events[1] !== e) begin
                errors++; $display("FAIL b2b_second: got %s want %s", ev_str(events[1]), ev_str(e));
            end
        end
        // Third frame abandoned by reset during its data bits.
        events.delete();
        bus.RX_IN = 1'b0; tick(32);
        bus.RX_IN = 1'b1; tick(32);
        bus.RX_IN = 1'b0; tick(40);
        rst = 1'b1; bus.RX_IN = 1'b1; tick(2);
        checks++;
        if ({bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR} !== 11'd0) begin
            errors++;
            $display("FAIL midframe_reset_outputs: got p_data=%h dv/pe/se=%b%b%b want all 0",
                     bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR);
        end
        rst = 1'b0;
        tick(400);
        checks++;
        if (events.size() !== 0 || bus.P_DATA !== 8'h00) begin
            errors++;
            $display("FAIL midframe_reset_quiet: got %0d pulses p_data=%h want 0 pulses p_data=00",
                     events.size(), bus.P_DATA);
        end
        send_frame(8, 0, 0, 8'h5A, 0, 1, 0, 0, t0);
        tick(4);
        checks++;
        e = mk_ev(t0 + 80, 1, 0, 0, 8'h5A);
        if (events.size() !== 1 || events[0] !== e) begin
            errors++;
            $display("FAIL after_reset_frame: got %0d events first %s want %s", events.size(),
                     events.size() > 0 ? ev_str(events[0]) : "none", ev_str(e));
        end
        model_pd = 8'h5A;
    endtask

    task automatic test_random();
        int pcfgs[7] = '{8, 16, 32, 0, 5, 63, 24};
        int t0;
        int pcfg;
        bit pen, ptyp, pbit, sbit, noise, scr;
        logic [W-1:0] d;
        events.delete();
        expq.delete();
        for (int n = 0; n < 30; n++) begin
            pcfg  = pcfgs[$urandom_range(6, 0)];
            pen   = 1'($urandom);
            ptyp  = 1'($urandom);
            d     = W'($urandom);
            pbit  = (^d) ^ ptyp ^ ($urandom_range(3, 0) == 0);
            sbit  = ($urandom_range(4, 0) != 0);
            noise = 1'($urandom);
            scr   = 1'($urandom);
            send_frame(pcfg, pen, ptyp, d, pbit, sbit, noise, scr, t0);
            expect_frame(pcfg, pen, ptyp, d, pbit, sbit, t0);
            tick(int'($urandom_range(3, 0)));
        end
        tick(4);
        checks++;
        if (events.size() !== expq.size()) begin
            errors++;
            $display("FAIL random_count: got %0d pulses want %0d", events.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < events.size(); i++) begin
            checks++;
            if (events[i] !== expq[i]) begin
                errors++;
                $display("FAIL random_frame_%0d: got %s want %s", i, ev_str(events[i]), ev_str(expq[i]));
            end
        end
    endtask

    initial begin
        model_pd = '0;
        test_reset();
        test_no_parity();
        test_parity();
        test_glitch();
        test_config_latch();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have port CLK, input, 1, single clock for all logic.
REQ-003 SHALL have port RST, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port RX_IN, input, 1, serial line, idle high, already synchronous to CLK.
REQ-005 SHALL have port PRESCALE, input, 6, oversampling ratio per bit; 16 and 32 are honoured, any other value is treated as 8.
REQ-006 SHALL have port PAR_EN, input, 1, 1 = parity bit present in the frame.
REQ-007 SHALL have port PAR_TYP, input, 1, 0 = even parity, 1 = odd parity.
REQ-008 SHALL have port P_DATA, output, DATA_WIDTH, last correctly received data word.
REQ-009 SHALL have port DATA_VALID, output, 1, one-cycle pulse when P_DATA is updated.
REQ-010 SHALL have port PAR_ERR, output, 1, one-cycle pulse when a frame has a parity mismatch.
REQ-011 SHALL have port STP_ERR, output, 1, one-cycle pulse when a frame's stop bit samples 0.

Function
REQ-012 SHALL receive frames in this order: start bit (0), then DATA_WIDTH data bits LSB first, then a parity bit if PAR_EN, then one stop bit (1).
REQ-013 SHALL use states IDLE, START, DATA, PARITY and STOP, with the following transitions.
- IDLE -> START: the cycle RX_IN is 0.
- START -> DATA or IDLE: at the bit end.
- DATA -> PARITY (PAR_EN=1) or STOP (PAR_EN=0): after bit DATA_WIDTH-1.
- PARITY -> STOP: at the bit end.
- STOP -> IDLE: at the bit end.
REQ-014 SHALL latch PRESCALE, PAR_EN and PAR_TYP on the IDLE->START transition; changes mid-frame SHALL NOT affect the current frame.
REQ-015 SHALL run an edge counter from 0 to P-1 per bit (P = latched prescale); the cycle of the IDLE->START transition is edge 0 of the start bit; the bit end is edge P-1.
REQ-016 SHALL sample RX_IN at edges P/2-1, P/2 and P/2+1, and take the sampled bit value as the majority of the three.
REQ-017 SHALL abort the frame on a sampled start bit of 1 (glitch): return to IDLE at the bit end, with no output pulses and P_DATA unchanged.
REQ-018 SHALL shift each data bit into a DATA_WIDTH-bit deserializer, LSB first; a bit counter runs 0..DATA_WIDTH-1 and then wraps to 0.
REQ-019 SHALL compute the expected parity as the XOR of the data bits XOR PAR_TYP, and SHALL flag a mismatch when the sampled parity bit differs from it.
REQ-020 SHALL, in the cycle after the stop-bit end, evaluate the frame.
- Good frame (stop sampled 1 and no parity mismatch): load P_DATA and pulse DATA_VALID for one cycle.
- Parity mismatch: pulse PAR_ERR.
- Stop sampled 0: pulse STP_ERR.
- Any error: P_DATA unchanged and no DATA_VALID.
REQ-021 SHALL allow PAR_ERR and STP_ERR to pulse in the same cycle.
REQ-022 SHALL give a latency from start edge 0 to the DATA_VALID cycle of P*(DATA_WIDTH+2) clocks without parity, or P*(DATA_WIDTH+3) clocks with parity.
REQ-023 SHALL accept back-to-back frames: a 0 on RX_IN in the first IDLE cycle after STOP starts a new frame; the output pulses of the previous frame SHALL still occur.
REQ-024 SHALL use no asynchronous paths other than RST; all outputs SHALL be registered.

Reset
REQ-025 SHALL, while RST=1, force the state to IDLE, all counters and the deserializer to 0, P_DATA to 0, and DATA_VALID, PAR_ERR and STP_ERR to 0.
REQ-026 SHALL, when RST is asserted mid-frame, abandon the frame with no output pulse, and SHALL, after RST is released, wait in IDLE for the next 0 on RX_IN.

Verification
REQ-027 SHALL cover: PRESCALE=8, PAR_EN=0, frame 0xA5 -> DATA_VALID pulses once at clock 80 after start edge 0, P_DATA=0xA5, no error pulses.
REQ-028 SHALL cover: PRESCALE=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity bit 0 -> DATA_VALID at clock 176, P_DATA=0x3C.
REQ-029 SHALL cover: PRESCALE=8, PAR_EN=1, PAR_TYP=1, data 0x01 with parity bit 1 (wrong) -> PAR_ERR pulse at clock 88, no DATA_VALID, P_DATA keeps its previous value.
REQ-030 SHALL cover: PRESCALE=8, stop bit driven 0 -> STP_ERR pulse at clock 80, no DATA_VALID.
REQ-031 SHALL cover: RX_IN low for 2 clocks then high -> no output pulses, state back to IDLE at clock 8.
REQ-032 SHALL cover: two back-to-back frames 0x55 then 0xAA at PRESCALE=32 -> two DATA_VALID pulses 320 clocks apart; then RST asserted mid-data of a third frame -> no pulse and all outputs 0.
